// File: rtl/ps2_dev_pkg.sv
// ps2_dev_pkg: shared FSM encoding, frame constants and parity helper for the PS/2 device generator
package ps2_dev_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_e;
  localparam int PS2_FRAME_BITS = 11;
  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_dev_fifo.sv
// ps2_dev_fifo: synchronous FIFO with head peek and occupancy count; pointers carry a wrap bit
module ps2_dev_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        din_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        head_o,
  output logic [$clog2(DEPTH):0]   cnt_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic do_push, do_pop;
  always_comb begin
    full_o  = wr_q[AW] != rd_q[AW] && wr_q[AW-1:0] == rd_q[AW-1:0];
    empty_o = wr_q == rd_q;
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_o   = wr_q - rd_q;
    head_o  = mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/ps2_dev_gen.sv
// ps2_dev_gen: PS/2 device-side frame generator serialising queued scan codes, honouring host inhibit.
// Define PS2_DEV_PARERR_EN to add parerr_i, which inverts the parity bit of the next frame to reach PARITY.
module ps2_dev_gen
  import ps2_dev_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYC    = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
`ifdef PS2_DEV_PARERR_EN
  input  logic                        parerr_i,
`endif
  input  logic [7:0]                  code_i,
  input  logic                        code_valid_i,
  output logic                        code_ready_o,
  input  logic                        ps2_clk_i,
  output logic                        ps2_clk_o,
  output logic                        ps2_dat_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o,
  output logic                        frame_done_o
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = $clog2(GAP_CYC + 1);
  state_e state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0] pos_q, pos_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [1:0] sync_q, sync_d;
  logic phase_q, phase_d;
  logic [7:0] head;
  logic [2:0] dbit;
  logic empty, full, inh, in_frame, div_last, bit_end, gap_last, abort, pop, par_flip;
  ps2_dev_fifo #(.DATA_W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (code_valid_i),
    .din_i   (code_i),
    .pop_i   (pop),
    .head_o  (head),
    .cnt_o   (fifo_cnt_o),
    .full_o  (full),
    .empty_o (empty)
  );
  // phase_q=0 is the released (high) half of a bit, 1 the driven-low half; pos_q is the frame bit index
  always_comb begin
    sync_d   = {sync_q[0], ps2_clk_i};
    inh      = !sync_q[1];
    in_frame = state_q inside {START, DATA, PARITY, STOP};
    div_last = div_q == DW'(CLK_DIV - 1);
    bit_end  = in_frame && phase_q && div_last;
    gap_last = gap_q == GW'(GAP_CYC - 1);
    abort    = inh && !phase_q && state_q inside {START, DATA, PARITY};
    pop      = state_q == STOP && bit_end;
    dbit     = pos_q[2:0] - 3'd1;
    state_d  = state_q;
    div_d    = div_q;
    phase_d  = phase_q;
    pos_d    = pos_q;
    gap_d    = gap_q;
    case (state_q)
      IDLE: state_d = (!empty && !inh) ? START : IDLE;
      GAP: begin
        gap_d   = gap_last ? '0 : gap_q + 1'b1;
        state_d = gap_last ? IDLE : GAP;
      end
      default: begin
        div_d   = div_last ? '0 : div_q + 1'b1;
        phase_d = phase_q ^ div_last;
        pos_d   = bit_end ? pos_q + 1'b1 : pos_q;
        if (bit_end)
          state_d = state_q == START ? DATA :
                    state_q == DATA  ? (pos_q == 4'(PS2_FRAME_BITS - 3) ? PARITY : DATA) :
                    state_q == PARITY ? STOP : GAP;
        if (abort || pop) begin
          state_d = GAP;
          div_d   = '0;
          phase_d = 1'b0;
          pos_d   = '0;
        end
      end
    endcase
    code_ready_o = !full;
    busy_o       = in_frame;
    frame_done_o = pop;
    ps2_clk_o    = !(in_frame && phase_q);
    ps2_dat_o    = state_q == START  ? 1'b0 :
                   state_q == DATA   ? head[dbit] :
                   state_q == PARITY ? odd_par(head) ^ par_flip : 1'b1;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      phase_q <= 1'b0;
      pos_q   <= '0;
      gap_q   <= '0;
      sync_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
      gap_q   <= gap_d;
      sync_q  <= sync_d;
    end
  end
`ifdef PS2_DEV_PARERR_EN
  // perr_q stays armed across aborts; perr_use_q marks the frame that actually carried the bad parity
  logic perr_q, perr_d, perr_use_q, perr_use_d;
  always_comb begin
    perr_d     = parerr_i || (perr_q && !(pop && perr_use_q));
    perr_use_d = (state_q == DATA && state_d == PARITY) ? perr_q : (in_frame && perr_use_q);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perr_q     <= 1'b0;
      perr_use_q <= 1'b0;
    end else begin
      perr_q     <= perr_d;
      perr_use_q <= perr_use_d;
    end
  end
  assign par_flip = perr_use_q;
`else
  assign par_flip = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_dev_gen.sv
// tb_ps2_dev_gen: host-side receiver model and scan-code scoreboard around ps2_dev_gen
module tb_ps2_dev_gen;
  localparam int CD = 4, FD = 4, GC = 16;
  logic clk = 1'b0, rst_i = 1'b1, code_valid_i = 1'b0, ps2_clk_i = 1'b1, parerr_i = 1'b0;
  logic [7:0] code_i = 8'h00;
  logic code_ready_o, ps2_clk_o, ps2_dat_o, busy_o, frame_done_o;
  logic [2:0] fifo_cnt_o;
  int total = 0, bad = 0;
  int cyc = 0, nb = 0, hi_run = 0, last_fall = 0, first_fall = 0, starts = 0, last_start = 0;
  int done_cnt = 0, done_cyc = 0, push_cnt = 0, last_push_cyc = 0, busy_cyc = 0;
  int d0, b0, s0, g, r_cyc, inh_left = 0;
  logic prev_clk = 1'b1, prev_busy = 1'b0, prev_done = 1'b0, perr_arm = 1'b0, perr_used = 1'b0;
  logic [3:0] hist = 4'hF;
  logic [10:0] bits = '0, last_bits = '0;
  logic [7:0] mcode;
  logic [7:0] exp_q[$], emit_q[$];
  logic par_log[$];
  logic [7:0] l2 [5] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};

  always #5 clk = ~clk;

  ps2_dev_gen #(.CLK_DIV(CD), .FIFO_DEPTH(FD), .GAP_CYC(GC)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
`ifdef PS2_DEV_PARERR_EN
    .parerr_i     (parerr_i),
`endif
    .code_i       (code_i),
    .code_valid_i (code_valid_i),
    .code_ready_o (code_ready_o),
    .ps2_clk_i    (ps2_clk_i),
    .ps2_clk_o    (ps2_clk_o),
    .ps2_dat_o    (ps2_dat_o),
    .busy_o       (busy_o),
    .fifo_cnt_o   (fifo_cnt_o),
    .frame_done_o (frame_done_o)
  );

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", n, got, want, $time);
    end
  endtask

  // Host receiver: samples data on each falling PS/2 clock, scoreboards completed frames
  always @(negedge clk) begin
    cyc++;
    hist = {hist[2:0], ps2_clk_i};
    if (rst_i) begin
      exp_q.delete();
      nb = 0; hi_run = 0; prev_clk = 1'b1; prev_busy = 1'b0; prev_done = 1'b0;
      perr_arm = 1'b0; perr_used = 1'b0;
    end else begin
      if (parerr_i) perr_arm = 1'b1;
      chk("cnt", fifo_cnt_o, exp_q.size());
      chk("ready", code_ready_o, exp_q.size() < FD);
      if (busy_o) begin
        chk("busy_nonempty", exp_q.size() != 0, 1);
        busy_cyc++;
      end
      if (busy_o && !prev_busy) begin
        starts++; last_start = cyc;
        chk("start_bit", ps2_dat_o, 0);
        chk("start_inhibit", hist[3], 1);
      end
      if (prev_clk && !ps2_clk_o) begin
        if (nb < 10) chk("fall_inhibit", hist[3], 1);
        if (nb > 0) chk("bit_period", cyc - last_fall, 2 * CD);
        else first_fall = cyc;
        if (nb < 11) bits[nb] = ps2_dat_o;
        if (nb == 9) perr_used = perr_arm;
        nb++; last_fall = cyc;
      end
      hi_run = ps2_clk_o ? hi_run + 1 : 0;
      if (hi_run > CD) nb = 0;
      if (frame_done_o) begin
        chk("done_single", prev_done, 0);
        chk("done_bits", nb, 11);
        chk("done_time", cyc - first_fall, 21 * CD - 1);
        chk("done_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mcode = exp_q.pop_front();
          chk("frame_code", bits[8:1], mcode);
          chk("frame_start", bits[0], 0);
          chk("frame_stop", bits[10], 1);
          chk("frame_parity", bits[9], (~^mcode) ^ perr_used);
        end
        if (perr_used) perr_arm = 1'b0;
        perr_used = 1'b0;
        emit_q.push_back(bits[8:1]);
        par_log.push_back(bits[9]);
        last_bits = bits;
        done_cnt++; done_cyc = cyc; nb = 0;
      end
      if (code_valid_i && code_ready_o) begin
        exp_q.push_back(code_i);
        push_cnt++; last_push_cyc = cyc;
      end
      prev_clk = ps2_clk_o; prev_busy = busy_o; prev_done = frame_done_o;
    end
  end

  task automatic push(input logic [7:0] c);
    int p = push_cnt;
    int k = 0;
    code_i = c;
    code_valid_i = 1'b1;
    while (push_cnt == p && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    code_valid_i = 1'b0;
    if (push_cnt == p) chk("timeout_push", push_cnt, p + 1);
  endtask

  task automatic wait_done(input int n, input int lim);
    int k = 0;
    while (done_cnt < n && k < lim) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (done_cnt < n) chk("timeout_done", done_cnt, n);
  endtask

  task automatic wait_bit(input int n);
    int k = 0;
    while (!(nb == n && hi_run == 1) && k < 500) begin
      @(posedge clk);
      k++;
    end
    if (k >= 500) chk("timeout_bit", nb, n);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clk", ps2_clk_o, 1);
    chk("rst_dat", ps2_dat_o, 1);
    chk("rst_ready", code_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_cnt", fifo_cnt_o, 0);
    chk("rst_done", frame_done_o, 0);
    rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // single frame of 0x1C
    b0 = busy_cyc; d0 = done_cnt;
    push(8'h1C);
    chk("t1_cnt_push", fifo_cnt_o, 1);
    wait_done(d0 + 1, 300);
    repeat (2) @(posedge clk);
    #1;
    chk("t1_bits", last_bits, 11'b10000111000);
    chk("t1_busy_cycles", busy_cyc - b0, 88);
    chk("t1_done_count", done_cnt - d0, 1);
    chk("t1_cnt_end", fifo_cnt_o, 0);
    // back-to-back pushes into a 4-deep queue
    emit_q.delete(); d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      push(l2[i]);
      if (i == 3) begin
        chk("t2_ready_full", code_ready_o, 0);
        chk("t2_cnt_full", fifo_cnt_o, 4);
      end
    end
    chk("t2_fifth_after_pop", last_push_cyc, done_cyc + 1);
    wait_done(d0 + 5, 2000);
    for (int i = 0; i < 5; i++) chk("t2_order", (i < emit_q.size()) ? emit_q[i] : 8'hxx, l2[i]);
    // inhibit during DATA bit 3 of 0xF0
    repeat (20) @(posedge clk);
    #1;
    d0 = done_cnt;
    push(8'hF0);
    wait_bit(4);
    #1;
    ps2_clk_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t3_rel_clk", ps2_clk_o, 1);
    chk("t3_rel_dat", ps2_dat_o, 1);
    chk("t3_rel_busy", busy_o, 0);
    repeat (17) @(posedge clk);
    #1;
    chk("t3_no_done", done_cnt - d0, 0);
    ps2_clk_i = 1'b1;
    wait_done(d0 + 1, 1000);
    chk("t3_retry_code", last_bits[8:1], 8'hF0);
    chk("t3_retry_parity", last_bits[9], 1);
    chk("t3_done_once", done_cnt - d0, 1);
    // inhibit held before the push
    repeat (30) @(posedge clk);
    #1;
    ps2_clk_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    s0 = starts; d0 = done_cnt;
    push(8'h12);
    repeat (30) @(posedge clk);
    #1;
    chk("t4_held", starts - s0, 0);
    r_cyc = cyc + 1;
    ps2_clk_i = 1'b1;
    wait_done(d0 + 1, 500);
    chk("t4_one_start", starts - s0, 1);
    chk("t4_start_delay", (last_start - r_cyc) >= 3, 1);
    // reset during PARITY with three codes queued
    repeat (30) @(posedge clk);
    #1;
    d0 = done_cnt;
    push(8'h11); push(8'h22); push(8'h33);
    wait_bit(9);
    #2;
    rst_i = 1'b1;
    #1;
    chk("t5_clk", ps2_clk_o, 1);
    chk("t5_dat", ps2_dat_o, 1);
    chk("t5_busy", busy_o, 0);
    chk("t5_cnt", fifo_cnt_o, 0);
    chk("t5_ready", code_ready_o, 1);
    chk("t5_done", frame_done_o, 0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    s0 = starts;
    repeat (400) @(posedge clk);
    #1;
    chk("t5_no_start", starts - s0, 0);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_cnt_after", fifo_cnt_o, 0);
    // randomized traffic with sporadic host inhibits
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk);
      #1;
      code_valid_i = ($urandom_range(0, ((c / 1000) % 2 == 1) ? 3 : 90) == 0);
      code_i = 8'($urandom);
      if (inh_left > 0) begin
        inh_left--;
        ps2_clk_i = 1'b0;
      end else begin
        ps2_clk_i = 1'b1;
        if ($urandom_range(0, 199) == 0) inh_left = $urandom_range(1, 30);
      end
    end
    code_valid_i = 1'b0;
    ps2_clk_i = 1'b1;
    g = 0;
    while ((exp_q.size() != 0 || busy_o) && g < 4000) begin
      @(posedge clk);
      g++;
    end
    #1;
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_cnt", fifo_cnt_o, 0);
`ifdef PS2_DEV_PARERR_EN
    repeat (30) @(posedge clk);
    #1;
    parerr_i = 1'b1;
    @(posedge clk);
    #1;
    parerr_i = 1'b0;
    par_log.delete(); d0 = done_cnt;
    push(8'h1C); push(8'h1C);
    wait_done(d0 + 2, 1000);
    chk("t6_par_first", (par_log.size() > 0) ? par_log[0] : 1'bx, 1);
    chk("t6_par_second", (par_log.size() > 1) ? par_log[1] : 1'bx, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
